// File: rtl/cam_pkg.sv
// Shared constants, types and FSM encoding for the 80x60 camera capture path.
package cam_pkg;

    localparam int c_img_cols    = 80;
    localparam int c_img_rows    = 60;
    localparam int c_nb_img_pxls = 13;
    localparam int c_nb_buf      = 12;

    typedef logic [c_nb_img_pxls-1:0] addr_t;
    typedef logic [c_nb_buf-1:0]      pxl_t;

    localparam addr_t      c_img_pxls = addr_t'(c_img_cols * c_img_rows);
    localparam logic [7:0] c_cam_cols = 8'd160;
    localparam logic [6:0] c_cam_rows = 7'd120;

    // Colour field MSB positions inside a buffer word, red on top.
    localparam int c_r_msb = 11;
    localparam int c_g_msb = 7;
    localparam int c_b_msb = 3;

    localparam pxl_t       c_tp_pxl    = 12'hF00;
    localparam logic [6:0] c_tp_col_lo = 7'd40;
    localparam logic [6:0] c_tp_col_hi = 7'd47;

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_VS_HIGH = 2'd1,
        S_FRAME   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sync_edge.sv
// N-flop synchroniser with one extra history flop for rising/falling edge pulses.
module sync_edge #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync_r;
    logic         q_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
            q_d    <= 1'b0;
        end else begin
            sync_r <= {sync_r[N-2:0], d};
            q_d    <= sync_r[N-1];
        end
    end

    assign q    = sync_r[N-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/cam_capture_80x60.sv
// Camera parallel-bus capture: QQVGA RGB444 decimated 2x2 into an 80x60 frame buffer.
// Build option CAPTURE_TESTPAT_EN adds tp_mode, which swaps camera pixels for a bar pattern.
//
//   state     | meaning
//   S_WAIT_VS | after reset, wait for vsync high so a partial frame is never stored
//   S_VS_HIGH | between frames, counters cleared on vsync falling
//   S_FRAME   | capturing lines; vsync rising ends the frame
module cam_capture_80x60
    import cam_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
`ifdef CAPTURE_TESTPAT_EN
    input  logic        tp_mode,
`endif
    output logic        buf_we,
    output addr_t       buf_addr,
    output pxl_t        buf_pxl,
    output logic        frame_done,
    output logic        frame_ok
);

    logic pclk_q, pclk_rise, pclk_fall;
    logic vsync_q, vsync_rise, vsync_fall;
    logic href_q, href_rise, href_fall;
    logic unused_sync;

    sync_edge #(.N(2)) u_sync_pclk (
        .clk(clk), .rst(rst), .d(cam_pclk),
        .q(pclk_q), .rise(pclk_rise), .fall(pclk_fall)
    );

    sync_edge #(.N(2)) u_sync_vsync (
        .clk(clk), .rst(rst), .d(cam_vsync),
        .q(vsync_q), .rise(vsync_rise), .fall(vsync_fall)
    );

    sync_edge #(.N(2)) u_sync_href (
        .clk(clk), .rst(rst), .d(cam_href),
        .q(href_q), .rise(href_rise), .fall(href_fall)
    );

    assign unused_sync = ^{pclk_q, pclk_fall, href_rise};

    // Data takes the same two flops as pclk, so it lines up with the detected rise.
    logic [7:0] data_s1, data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_s1 <= '0;
            data_q  <= '0;
        end else begin
            data_s1 <= cam_data;
            data_q  <= data_s1;
        end
    end

    cap_state_t state_q, state_d;
    logic       clr_frame, cap_en, end_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_WAIT_VS;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        clr_frame = 1'b0;
        cap_en    = 1'b0;
        end_frame = 1'b0;
        unique case (state_q)
            S_WAIT_VS: begin
                if (vsync_q) state_d = S_VS_HIGH;
            end
            S_VS_HIGH: begin
                if (vsync_fall) begin
                    clr_frame = 1'b1;
                    state_d   = S_FRAME;
                end
            end
            S_FRAME: begin
                if (vsync_rise) begin
                    end_frame = 1'b1;
                    state_d   = S_VS_HIGH;
                end else begin
                    cap_en = 1'b1;
                end
            end
            default: state_d = S_WAIT_VS;
        endcase
    end

    logic       byte_ph;
    logic [3:0] red_q;
    logic [7:0] col_cnt;
    logic [6:0] row_cnt;
    addr_t      wr_addr;
    logic       byte_evt, pxl_done, do_write;
    pxl_t       cam_pxl, new_pxl;

    assign byte_evt = cap_en & pclk_rise & href_q;
    assign pxl_done = byte_evt & byte_ph;

    assign cam_pxl[c_r_msb -: 4] = red_q;
    assign cam_pxl[c_g_msb -: 4] = data_q[7:4];
    assign cam_pxl[c_b_msb -: 4] = data_q[3:0];

`ifdef CAPTURE_TESTPAT_EN
    pxl_t tp_pxl;

    assign tp_pxl  = (col_cnt[7:1] >= c_tp_col_lo && col_cnt[7:1] <= c_tp_col_hi) ? c_tp_pxl : '0;
    assign new_pxl = tp_mode ? tp_pxl : cam_pxl;
`else
    assign new_pxl = cam_pxl;
`endif

    // wr_addr walks stored pixels in raster order, so it equals (row/2)*80 + col/2.
    assign do_write = pxl_done & ~row_cnt[0] & ~col_cnt[0]
                    & (col_cnt < c_cam_cols) & (row_cnt < c_cam_rows)
                    & (wr_addr < c_img_pxls);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_ph    <= 1'b0;
            red_q      <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            wr_addr    <= '0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_pxl    <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
        end else begin
            buf_we     <= 1'b0;
            frame_done <= 1'b0;

            if (clr_frame) begin
                row_cnt <= '0;
                col_cnt <= '0;
                byte_ph <= 1'b0;
                wr_addr <= '0;
            end

            if (end_frame) begin
                frame_done <= 1'b1;
                frame_ok   <= (wr_addr == c_img_pxls);
            end

            if (cap_en) begin
                // A dangling odd byte dies here instead of pairing into the next line.
                if (!href_q) byte_ph <= 1'b0;

                if (href_fall) begin
                    col_cnt <= '0;
                    if (col_cnt != '0 && row_cnt < c_cam_rows) row_cnt <= row_cnt + 7'd1;
                end

                if (byte_evt) begin
                    byte_ph <= ~byte_ph;
                    if (!byte_ph) red_q <= data_q[3:0];
                end

                if (pxl_done && col_cnt < c_cam_cols) col_cnt <= col_cnt + 8'd1;

                if (do_write) begin
                    buf_we   <= 1'b1;
                    buf_addr <= wr_addr;
                    buf_pxl  <= new_pxl;
                    wr_addr  <= wr_addr + addr_t'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_80x60.sv
// Directed bench for cam_capture_80x60: table of frame scenarios plus a reset-mid-frame sequence.
module tb_cam_capture_80x60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
`ifdef CAPTURE_TESTPAT_EN
    logic        tp_mode = 1'b0;
`endif
    logic        buf_we;
    logic [12:0] buf_addr;
    logic [11:0] buf_pxl;
    logic        frame_done;
    logic        frame_ok;

    cam_capture_80x60 dut (
        .clk(clk),
        .rst(rst),
        .cam_pclk(cam_pclk),
        .cam_vsync(cam_vsync),
        .cam_href(cam_href),
        .cam_data(cam_data),
`ifdef CAPTURE_TESTPAT_EN
        .tp_mode(tp_mode),
`endif
        .buf_we(buf_we),
        .buf_addr(buf_addr),
        .buf_pxl(buf_pxl),
        .frame_done(frame_done),
        .frame_ok(frame_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-owned frame marker and pattern select, read by the monitor.
    int frame_id = 0;
    bit tp_sel = 1'b0;

    // Monitor-owned tallies.
    int          wr_total = 0;
    int          done_total = 0;
    int          addr_bad = 0;
    int          pxl_bad = 0;
    int          last_addr = -1;
    logic [11:0] last_pxl = '0;
    logic [11:0] pxl81 = '0;
    int          mon_idx = 0;
    int          seen_id = 0;

    function automatic logic [11:0] exp_pxl(input int a, input bit tp);
        int         r, c;
        logic [7:0] rr, cc;
        c = a % 80;
        r = a / 80;
        if (tp) return (c >= 40 && c <= 47) ? 12'hF00 : 12'h000;
        cc = 8'(2 * c);
        rr = 8'(2 * r);
        return {cc[3:0], rr[3:0], 4'hA};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (frame_id != seen_id) begin
                seen_id = frame_id;
                mon_idx = 0;
            end
            if (frame_done) done_total++;
            if (buf_we) begin
                if (int'(buf_addr) != mon_idx) addr_bad++;
                if (buf_pxl != exp_pxl(mon_idx, tp_sel)) pxl_bad++;
                if (mon_idx == 81) pxl81 = buf_pxl;
                last_addr = int'(buf_addr);
                last_pxl  = buf_pxl;
                mon_idx++;
                wr_total++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Camera byte k of line r, n bytes long; an odd trailing byte is a marker value.
    function automatic logic [7:0] line_byte(input int r, input int k, input int n);
        logic [7:0] cb, rb;
        if ((n % 2 == 1) && (k == n - 1)) return 8'hEE;
        cb = 8'(k / 2);
        rb = 8'(r);
        return (k % 2 == 0) ? {4'h5, cb[3:0]} : {rb[3:0], 4'hA};
    endfunction

    task automatic pclk_byte(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bytes(input int r, input int k0, input int k1, input int n);
        for (int k = k0; k < k1; k++) pclk_byte(line_byte(r, k, n));
    endtask

    task automatic end_line();
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_line(input int r, input int n);
        cam_href = 1'b1;
        send_bytes(r, 0, n, n);
        end_line();
    endtask

    task automatic vs_start();
        cam_vsync = 1'b1;
        repeat (20) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic vs_end();
        cam_vsync = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    typedef struct {
        int          n_lines;
        int          even_b;
        int          odd_b;
        bit          tp;
        int          exp_wr;
        int          exp_ok;
        int          exp_last_addr;
        logic [11:0] exp_last_pxl;
        logic [11:0] exp_p81;
    } vec_t;

`ifdef CAPTURE_TESTPAT_EN
    localparam int N_VEC = 5;
`else
    localparam int N_VEC = 4;
`endif

    vec_t vecs[N_VEC];
    int   w0, d0, a0, p0;

    initial begin
        vecs[0] = '{120, 320, 320, 1'b0, 4800, 1, 4799, 12'hE6A, 12'h22A};
        vecs[1] = '{ 50, 320, 320, 1'b0, 2000, 0, 1999, 12'hE0A, 12'h22A};
        vecs[2] = '{125, 340, 340, 1'b0, 4800, 1, 4799, 12'hE6A, 12'h22A};
        vecs[3] = '{  6, 321, 320, 1'b0,  240, 0,  239, 12'hE4A, 12'h22A};
`ifdef CAPTURE_TESTPAT_EN
        vecs[4] = '{120, 320, 320, 1'b1, 4800, 1, 4799, 12'h000, 12'h000};
`endif

        repeat (3) @(negedge clk);
        chk("reset buf_we", int'(buf_we), 0);
        chk("reset buf_addr", int'(buf_addr), 0);
        chk("reset buf_pxl", int'(buf_pxl), 0);
        chk("reset frame_done", int'(frame_done), 0);
        chk("reset frame_ok", int'(frame_ok), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Capture 30 full lines plus 50 pixels of line 30, then reset.
        frame_id++;
        w0 = wr_total; a0 = addr_bad; p0 = pxl_bad;
        vs_start();
        for (int r = 0; r < 30; r++) send_line(r, 320);
        cam_href = 1'b1;
        send_bytes(30, 0, 100, 320);
        repeat (4) @(negedge clk);
        chk("pre-reset writes", wr_total - w0, 15 * 80 + 25);
        chk("pre-reset addr order", addr_bad - a0, 0);
        chk("pre-reset pixels", pxl_bad - p0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst buf_we", int'(buf_we), 0);
        chk("midrst buf_addr", int'(buf_addr), 0);
        chk("midrst buf_pxl", int'(buf_pxl), 0);
        chk("midrst frame_done", int'(frame_done), 0);
        chk("midrst frame_ok", int'(frame_ok), 0);
        @(negedge clk);
        rst = 1'b0;
        frame_id++;
        w0 = wr_total; d0 = done_total;
        send_bytes(30, 100, 320, 320);
        end_line();
        for (int r = 31; r < 40; r++) send_line(r, 320);
        chk("post-reset writes", wr_total - w0, 0);
        chk("post-reset frame_done", done_total - d0, 0);

        for (int i = 0; i < N_VEC; i++) begin
            tp_sel = vecs[i].tp;
`ifdef CAPTURE_TESTPAT_EN
            tp_mode = vecs[i].tp;
`endif
            frame_id++;
            w0 = wr_total; d0 = done_total; a0 = addr_bad; p0 = pxl_bad;
            vs_start();
            for (int r = 0; r < vecs[i].n_lines; r++)
                send_line(r, (r % 2 == 0) ? vecs[i].even_b : vecs[i].odd_b);
            vs_end();
            chk($sformatf("v%0d writes", i), wr_total - w0, vecs[i].exp_wr);
            chk($sformatf("v%0d frame_done", i), done_total - d0, 1);
            chk($sformatf("v%0d frame_ok", i), int'(frame_ok), vecs[i].exp_ok);
            chk($sformatf("v%0d addr order", i), addr_bad - a0, 0);
            chk($sformatf("v%0d pixel errors", i), pxl_bad - p0, 0);
            chk($sformatf("v%0d last addr", i), last_addr, vecs[i].exp_last_addr);
            chk($sformatf("v%0d last pixel", i), int'(last_pxl), int'(vecs[i].exp_last_pxl));
            chk($sformatf("v%0d pixel at 81", i), int'(pxl81), int'(vecs[i].exp_p81));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
